// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Provides the FSM state type, the port identifiers used by the winner
// select, and a helper that derives the byte-mask width from the data width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  localparam logic ARB_PORT_I = 1'b0;
  localparam logic ARB_PORT_D = 1'b1;

  // One byte enable per 8 data bits.
  function automatic int mask_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select and starvation guard for the memory arbiter.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   idle          arbiter FSM is in ARB_IDLE (arbitration edge)
//   i_req, d_req  requests from the fetch and load/store masters
//   grant         a grant is issued at this edge
//   win           winning port (ARB_PORT_I / ARB_PORT_D), valid with grant
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic i_req,
  input  logic d_req,
  output logic grant,
  output logic win
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] streak_r;
  logic          at_limit_s;

  // D wins contention unless I has already been passed over LIMIT times.
  always_comb begin
    at_limit_s = (streak_r == LIMIT);
    grant      = idle & (i_req | d_req);
    if (d_req && !(i_req && at_limit_s)) begin
      win = ARB_PORT_D;
    end else begin
      win = ARB_PORT_I;
    end
  end

  // Streak of D grants issued while I was waiting; only moves at idle edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_r <= '0;
    end else if (idle) begin
      if (!i_req) begin
        streak_r <= '0;
      end else if (win == ARB_PORT_I) begin
        streak_r <= '0;
      end else if (!at_limit_s) begin
        streak_r <= streak_r + SW'(1);
      end else begin
        streak_r <= streak_r;
      end
    end else begin
      streak_r <= streak_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (I) and
// load/store (D). One transaction outstanding at a time; D preferred, with
// a starvation guard for I. All outputs are registered.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   i_*/d_* req,we,addr,wdata,wmask master requests and payloads
//   i_gnt/d_gnt                    one-cycle pulse: request captured
//   i_rvalid/d_rvalid, *_rdata     completion pulse and held read data
//   s_req,s_we,s_addr,s_wdata,s_wmask  registered request toward memory
//   s_ack, s_rdata                 memory completion and read data
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_req,
  input  logic                               i_we,
  input  logic [ADDR_WIDTH-1:0]              i_addr,
  input  logic [DATA_WIDTH-1:0]              i_wdata,
  input  logic [mask_width(DATA_WIDTH)-1:0]  i_wmask,
  output logic                               i_gnt,
  output logic                               i_rvalid,
  output logic [DATA_WIDTH-1:0]              i_rdata,
  input  logic                               d_req,
  input  logic                               d_we,
  input  logic [ADDR_WIDTH-1:0]              d_addr,
  input  logic [DATA_WIDTH-1:0]              d_wdata,
  input  logic [mask_width(DATA_WIDTH)-1:0]  d_wmask,
  output logic                               d_gnt,
  output logic                               d_rvalid,
  output logic [DATA_WIDTH-1:0]              d_rdata,
  output logic                               s_req,
  output logic                               s_we,
  output logic [ADDR_WIDTH-1:0]              s_addr,
  output logic [DATA_WIDTH-1:0]              s_wdata,
  output logic [mask_width(DATA_WIDTH)-1:0]  s_wmask,
  input  logic                               s_ack,
  input  logic [DATA_WIDTH-1:0]              s_rdata
);

  arb_state_t state_r;
  logic       idle_s;
  logic       pick_grant_s;
  logic       pick_win_s;

  // Arbitration only happens while nothing is outstanding.
  always_comb begin
    idle_s = (state_r == ARB_IDLE);
  end

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk  (clk),
    .rst  (rst),
    .idle (idle_s),
    .i_req(i_req),
    .d_req(d_req),
    .grant(pick_grant_s),
    .win  (pick_win_s)
  );

  // Arbiter FSM: grant/capture payload in IDLE, wait for s_ack in BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ARB_IDLE;
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      s_req    <= 1'b0;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_wmask  <= '0;
    end else begin
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          // A stray s_ack here is deliberately ignored.
          if (pick_grant_s) begin
            s_req <= 1'b1;
            if (pick_win_s == ARB_PORT_D) begin
              s_we    <= d_we;
              s_addr  <= d_addr;
              s_wdata <= d_wdata;
              s_wmask <= d_wmask;
              d_gnt   <= 1'b1;
              state_r <= ARB_BUSY_D;
            end else begin
              s_we    <= i_we;
              s_addr  <= i_addr;
              s_wdata <= i_wdata;
              s_wmask <= i_wmask;
              i_gnt   <= 1'b1;
              state_r <= ARB_BUSY_I;
            end
          end else begin
            s_req <= 1'b0;
          end
        end
        ARB_BUSY_I: begin
          if (s_ack) begin
            if (!s_we) begin
              i_rdata <= s_rdata;
            end else begin
              i_rdata <= i_rdata;
            end
            i_rvalid <= 1'b1;
            s_req    <= 1'b0;
            state_r  <= ARB_IDLE;
          end else begin
            state_r <= ARB_BUSY_I;
          end
        end
        ARB_BUSY_D: begin
          if (s_ack) begin
            if (!s_we) begin
              d_rdata <= s_rdata;
            end else begin
              d_rdata <= d_rdata;
            end
            d_rvalid <= 1'b1;
            s_req    <= 1'b0;
            state_r  <= ARB_IDLE;
          end else begin
            state_r <= ARB_BUSY_D;
          end
        end
        default: begin
          s_req   <= 1'b0;
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_we, d_req, d_we;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic [3:0]  i_wmask, d_wmask;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic        s_req, s_we, s_ack;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_d_order;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_wmask(i_wmask), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wmask(s_wmask), .s_ack(s_ack), .s_rdata(s_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_we = 1'b0; i_addr = 32'h0; i_wdata = 32'h0; i_wmask = 4'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wmask = 4'h0;
    s_ack = 1'b0; s_rdata = 32'h0;
    exp_d_order = 10'b0111101111;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_s_req", {31'd0, s_req}, 32'd0);
    chk("rst_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);

    // Single I read, W=0
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0010;
    tick();
    chk("t1_i_gnt", {31'd0, i_gnt}, 32'd1);
    chk("t1_s_req", {31'd0, s_req}, 32'd1);
    chk("t1_s_addr", s_addr, 32'h10);
    chk("t1_s_we", {31'd0, s_we}, 32'd0);
    i_req = 1'b0; s_ack = 1'b1; s_rdata = 32'h0000_0013;
    tick();
    s_ack = 1'b0;
    chk("t1_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    chk("t1_i_rdata", i_rdata, 32'h13);
    chk("t1_s_req_drop", {31'd0, s_req}, 32'd0);
    tick();
    chk("t1_rvalid_pulse", {31'd0, i_rvalid}, 32'd0);

    // Simultaneous I read and D write: D first
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
    tick();
    chk("t2_d_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);
    chk("t2_s_wmask", {28'd0, s_wmask}, 32'h3);
    chk("t2_s_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("t2_s_we", {31'd0, s_we}, 32'd1);
    d_req = 1'b0; s_ack = 1'b1; s_rdata = 32'hAAAA_5555;
    tick();
    s_ack = 1'b0;
    chk("t2_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("t2_d_rdata_kept", d_rdata, 32'd0);
    chk("t2_i_not_yet", {31'd0, i_gnt}, 32'd0);
    tick();
    chk("t2_i_gnt", {31'd0, i_gnt}, 32'd1);
    chk("t2_i_addr", s_addr, 32'h200);
    i_req = 1'b0; s_ack = 1'b1; s_rdata = 32'h77;
    tick();
    s_ack = 1'b0;
    chk("t2_i_rdata", i_rdata, 32'h77);

    // Continuous requests: starvation guard order
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("t3_order_%0d", k), {30'd0, i_gnt, d_gnt},
          exp_d_order[k] ? 32'd1 : 32'd2);
      s_ack = 1'b1; s_rdata = 32'h0;
      tick();
      s_ack = 1'b0;
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // D read with W=3; I request raised mid-wait
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    tick();
    chk("t4_d_gnt", {31'd0, d_gnt}, 32'd1);
    d_req = 1'b0; d_addr = 32'h999;
    chk("t4_wait0", {s_req, s_addr[30:0]}, {1'b1, 31'h300});
    tick();
    chk("t4_wait1", {s_req, s_addr[30:0]}, {1'b1, 31'h300});
    i_req = 1'b1; i_addr = 32'h440;
    tick();
    chk("t4_wait2", {s_req, s_addr[30:0]}, {1'b1, 31'h300});
    chk("t4_no_i_gnt", {31'd0, i_gnt}, 32'd0);
    tick();
    chk("t4_wait3", {s_req, s_addr[30:0]}, {1'b1, 31'h300});
    s_ack = 1'b1; s_rdata = 32'h1234_5678;
    tick();
    s_ack = 1'b0;
    chk("t4_d_rvalid", {30'd0, i_gnt, d_rvalid}, 32'd1);
    chk("t4_d_rdata", d_rdata, 32'h1234_5678);
    tick();
    chk("t4_i_gnt", {31'd0, i_gnt}, 32'd1);
    chk("t4_i_addr", s_addr, 32'h440);
    i_req = 1'b0; s_ack = 1'b1; s_rdata = 32'h0000_0ABC;
    tick();
    s_ack = 1'b0;
    chk("t4_i_rdata", i_rdata, 32'h0000_0ABC);

    // Asynchronous reset mid-wait in BUSY_D
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    tick();
    chk("t5_d_gnt", {31'd0, d_gnt}, 32'd1);
    d_req = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_async_s_req", {31'd0, s_req}, 32'd0);
    chk("t5_async_gnt_rv", {28'd0, i_gnt, d_gnt, i_rvalid, d_rvalid}, 32'd0);
    chk("t5_async_rdata", d_rdata, 32'd0);
    tick();
    rst = 1'b0;
    s_ack = 1'b1; s_rdata = 32'hBAD0_BAD0;
    tick();
    s_ack = 1'b0;
    chk("t5_no_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("t5_idle", {31'd0, s_req}, 32'd0);
    d_req = 1'b1; d_addr = 32'h700;
    tick();
    chk("t5_fresh_gnt", {31'd0, d_gnt}, 32'd1);
    d_req = 1'b0; s_ack = 1'b1; s_rdata = 32'h55;
    tick();
    s_ack = 1'b0;
    chk("t5_fresh_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("t5_fresh_rdata", d_rdata, 32'h55);
    tick();

    // Spurious s_ack while idle
    s_ack = 1'b1; s_rdata = 32'hFFFF_FFFF;
    tick();
    chk("t6_no_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    tick();
    s_ack = 1'b0;
    chk("t6_no_rvalid2", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    chk("t6_i_rdata", i_rdata, 32'd0);
    chk("t6_d_rdata", d_rdata, 32'h55);
    chk("t6_no_s_req", {31'd0, s_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
